usb_utm_tx: RTL

UTMI transmit side of the FS (12 Mb/s) macrocell, the counterpart of the UTM receive path.
- Accepts bytes from the SIE over the UTMI tx handshake.
- Prepends SYNC, bit-stuffs, NRZI-encodes, appends EOP, and drives the D+/D- front-end pair with output enable.
- clk runs at CLK_PER_BIT times the bit rate.

---
 rtl/usb_utmi_pkg.sv | 34 +++
 rtl/usb_utm_tx_line.sv | 57 +++++
 rtl/usb_utm_tx.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/usb_utmi_pkg.sv
// Shared UTMI types and constants for the FS macrocell (transmit and receive paths).
package usb_utmi_pkg;

  typedef logic [7:0] bus8_t;

  // SYNC sent LSB first: seven 0s then a 1, giving KJKJKJKK on the line from idle J
  localparam bus8_t       USB_SYNC_PATTERN = 8'h80;
  localparam int unsigned USB_STUFF_BITS_N = 6;
  localparam int unsigned USB_EOP_SE0_BITS = 2;

  // bit0 = D+, bit1 = D-
  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_J   = 2'b01,
    LS_K   = 2'b10,
    LS_SE1 = 2'b11
  } utmi_line_state_t;

  typedef enum logic [1:0] {
    TX_WAIT_S,
    SEND_SYNC_S,
    SEND_DATA_S,
    SEND_EOP_S
  } utmi_tx_state_t;

  // Command to the line driver, applied on a bit update
  typedef enum logic [1:0] {
    LINE_NRZI,
    LINE_SE0,
    LINE_J,
    LINE_IDLE
  } utmi_tx_line_cmd_t;

endpackage

// File: rtl/usb_utm_tx_line.sv
// NRZI encoder and line-state to D+/D-/OE mapping for the UTM transmit path.
module usb_utm_tx_line
  import usb_utmi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_strobe,
  input  logic              bit_val,
  input  utmi_tx_line_cmd_t cmd,
  output logic              dp_tx,
  output logic              dn_tx,
  output logic              tx_oe
);

  utmi_line_state_t level_q;
  utmi_line_state_t drive_q;
  utmi_line_state_t level_tgl;
  logic             oe_q;

  assign level_tgl = (level_q == LS_J) ? LS_K : LS_J;

  // Update NRZI level and driven line state on each bit boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= LS_J;
      drive_q <= LS_J;
      oe_q    <= 1'b0;
    end else if (bit_strobe) begin
      case (cmd)
        LINE_NRZI: begin
          level_q <= bit_val ? level_q : level_tgl;
          drive_q <= bit_val ? level_q : level_tgl;
          oe_q    <= 1'b1;
        end
        LINE_SE0: begin
          drive_q <= LS_SE0;
          oe_q    <= 1'b1;
        end
        LINE_J: begin
          level_q <= LS_J;
          drive_q <= LS_J;
          oe_q    <= 1'b1;
        end
        LINE_IDLE: begin
          level_q <= LS_J;
          drive_q <= LS_J;
          oe_q    <= 1'b0;
        end
      endcase
    end
  end

  assign dp_tx = drive_q[0];
  assign dn_tx = drive_q[1];
  assign tx_oe = oe_q;

endmodule

// File: rtl/usb_utm_tx.sv
// UTMI FS transmit path: SYNC, bit stuffing, NRZI and EOP onto D+/D-.
// Optional abort input enabled by defining USB_UTM_TX_ABORT_EN.
module usb_utm_tx
  import usb_utmi_pkg::*;
#(
  parameter int CLK_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       tx_valid,
`ifdef USB_UTM_TX_ABORT_EN
  input  logic       tx_abort,
`endif
  output logic       tx_ready,
  output logic       dp_tx,
  output logic       dn_tx,
  output logic       tx_oe,
  output logic       tx_active
);

  localparam int PW = $clog2(CLK_PER_BIT);
  localparam logic [2:0] ABORT_LAST = 3'd6;  // 7 held-level bits on abort

  utmi_tx_state_t    state_q, state_d;
  logic [PW-1:0]     phase_q;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  bus8_t             shift_q, shift_d;
  logic [2:0]        ones_q, ones_d;
  logic              abort_q, abort_d;
  logic              abort_req;
  logic              strobe;
  logic              stuff_due;
  logic              line_upd;
  logic              line_bit;
  utmi_tx_line_cmd_t line_cmd;

  assign strobe    = (phase_q == PW'(CLK_PER_BIT - 1));
  assign stuff_due = (ones_q == 3'(USB_STUFF_BITS_N));
  assign tx_active = (state_q != TX_WAIT_S);

`ifdef USB_UTM_TX_ABORT_EN
  assign abort_req = tx_abort && !abort_q && (state_q == SEND_DATA_S);
`else
  assign abort_req = 1'b0;
`endif

  // Bit-phase counter, parked at zero while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       phase_q <= '0;
    else if (state_q == TX_WAIT_S) phase_q <= '0;
    else if (strobe)               phase_q <= '0;
    else                           phase_q <= phase_q + PW'(1);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= TX_WAIT_S;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ones_q    <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ones_q    <= ones_d;
      abort_q   <= abort_d;
    end
  end

  // Next state: bit_cnt indexes the last SYNC/data/abort/EOP bit put on the line;
  // a stuff bit leaves bit_cnt and the shifter untouched, so the byte-load check
  // naturally waits until the stuff bit has gone out.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ones_d    = ones_q;
    abort_d   = abort_q;
    case (state_q)
      TX_WAIT_S: begin
        if (tx_valid) begin
          state_d   = SEND_SYNC_S;
          bit_cnt_d = '0;
          ones_d    = '0;
        end
      end
      SEND_SYNC_S, SEND_DATA_S: begin
        if (strobe) begin
          if (abort_q) begin
            if (bit_cnt_q == ABORT_LAST) begin
              state_d   = SEND_EOP_S;
              bit_cnt_d = '0;
              abort_d   = 1'b0;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else if (abort_req) begin
            abort_d   = 1'b1;
            bit_cnt_d = '0;
            ones_d    = '0;
          end else if (stuff_due) begin
            ones_d = '0;
          end else if (bit_cnt_q != 3'd7) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (state_q == SEND_DATA_S) begin
              shift_d = shift_q >> 1;
              ones_d  = shift_q[1] ? ones_q + 3'd1 : '0;
            end
          end else if (tx_valid) begin
            state_d   = SEND_DATA_S;
            bit_cnt_d = '0;
            shift_d   = data_in;
            ones_d    = data_in[0] ? ones_q + 3'd1 : '0;
          end else begin
            state_d   = SEND_EOP_S;
            bit_cnt_d = '0;
            ones_d    = '0;
          end
        end
      end
      SEND_EOP_S: begin
        if (strobe) begin
          if (bit_cnt_q == 3'(USB_EOP_SE0_BITS)) begin
            state_d   = TX_WAIT_S;
            bit_cnt_d = '0;
            ones_d    = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
    endcase
  end

  // Outputs: line command for the next bit and the tx_ready handshake
  always_comb begin
    line_upd = 1'b0;
    line_bit = 1'b1;
    line_cmd = LINE_NRZI;
    tx_ready = 1'b0;
    case (state_q)
      TX_WAIT_S: begin
        if (tx_valid) begin
          line_upd = 1'b1;
          line_bit = USB_SYNC_PATTERN[0];
        end
      end
      SEND_SYNC_S, SEND_DATA_S: begin
        if (strobe) begin
          line_upd = 1'b1;
          if (abort_q) begin
            if (bit_cnt_q == ABORT_LAST) line_cmd = LINE_SE0;
          end else if (abort_req) begin
            line_bit = 1'b1;
          end else if (stuff_due) begin
            line_bit = 1'b0;
          end else if (bit_cnt_q != 3'd7) begin
            line_bit = (state_q == SEND_SYNC_S) ? USB_SYNC_PATTERN[bit_cnt_q + 3'd1]
                                                : shift_q[1];
          end else if (tx_valid) begin
            line_bit = data_in[0];
            tx_ready = 1'b1;
          end else begin
            line_cmd = LINE_SE0;
          end
        end
      end
      SEND_EOP_S: begin
        if (strobe) begin
          line_upd = 1'b1;
          if (bit_cnt_q < 3'(USB_EOP_SE0_BITS - 1))       line_cmd = LINE_SE0;
          else if (bit_cnt_q == 3'(USB_EOP_SE0_BITS - 1)) line_cmd = LINE_J;
          else                                            line_cmd = LINE_IDLE;
        end
      end
    endcase
  end

  usb_utm_tx_line u_line (
    .clk        (clk),
    .rst        (rst),
    .bit_strobe (line_upd),
    .bit_val    (line_bit),
    .cmd        (line_cmd),
    .dp_tx      (dp_tx),
    .dn_tx      (dn_tx),
    .tx_oe      (tx_oe)
  );

endmodule
